// File: rtl/ram_stream_reader.sv
// ram_stream_reader
// Reads a contiguous, wrap-around block of words from a single-port RAM that
// has a registered read (one cycle of latency). The words are presented in
// address order on a valid/ready stream. A 2-entry buffer absorbs the read
// latency, so one word per cycle is delivered while streamReady stays high.
//
// Ports
//   clk, rstN    clock (posedge); asynchronous active-low reset
//   start        one-cycle command strobe, sampled only while idle
//   startAddr    first RAM address of the block
//   wordCount    number of words to read, 0..DEPTH
//   ramWrEn      RAM write enable, always 0
//   ramDataIn    RAM write data, always 0
//   ramAddress   RAM address (the current read pointer)
//   ramDataOut   RAM read data, valid one cycle after the address
//   streamData   word at the head of the buffer
//   streamValid  streamData holds a word
//   streamReady  consumer takes the word this cycle
//   busy         a transfer is in progress
//   done         one-cycle pulse when a command completes
module ram_stream_reader #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] startAddr,
  input  logic [ADDR_WIDTH:0]   wordCount,
  output logic                  ramWrEn,
  output logic [DATA_WIDTH-1:0] ramDataIn,
  output logic [ADDR_WIDTH-1:0] ramAddress,
  input  logic [DATA_WIDTH-1:0] ramDataOut,
  output logic [DATA_WIDTH-1:0] streamData,
  output logic                  streamValid,
  input  logic                  streamReady,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] cur_addr_reg, cur_addr_next;
  logic [ADDR_WIDTH:0]   remaining_reg, remaining_next;
  logic                  inflight_reg, inflight_next;
  logic                  done_reg, done_next;
  logic [1:0]            fifo_count_reg, fifo_count_next;
  logic                  rd_ptr_reg, wr_ptr_reg;
  logic [DATA_WIDTH-1:0] fifo_mem [2];

  logic       push, pop, issue;
  logic [2:0] occupancy;

  // The RAM is only ever read.
  assign ramWrEn    = 1'b0;
  assign ramDataIn  = '0;
  assign ramAddress = cur_addr_reg;

  assign streamValid = (fifo_count_reg != 2'd0);
  assign streamData  = fifo_mem[rd_ptr_reg];
  assign busy        = (state_reg == RUN);
  assign done        = done_reg;

  // A read issued last cycle lands in the buffer on this edge.
  assign push = inflight_reg;
  assign pop  = streamValid && streamReady;

  // Buffer slots that will be claimed after this edge (stored + in flight,
  // minus the word leaving now). A new read is only issued if a slot
  // remains, which keeps the 2-entry buffer from ever overflowing.
  assign occupancy = {1'b0, fifo_count_reg} + {2'b00, inflight_reg} - {2'b00, pop};

  always_comb begin
    state_next     = state_reg;
    cur_addr_next  = cur_addr_reg;
    remaining_next = remaining_reg;
    inflight_next  = 1'b0;
    done_next      = 1'b0;
    issue          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (wordCount != '0) begin
            cur_addr_next  = startAddr;
            remaining_next = wordCount;
            state_next     = RUN;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      RUN: begin
        issue = (remaining_reg != '0) && (occupancy < 3'd2);
        if (issue) begin
          // Address width matches DEPTH, so the increment wraps naturally.
          cur_addr_next  = cur_addr_reg + 1'b1;
          remaining_next = remaining_reg - 1'b1;
          inflight_next  = 1'b1;
        end
        // Finished once nothing is left to read, nothing is in flight and
        // the buffer drains on this edge.
        if ((remaining_reg == '0) && !inflight_reg && (occupancy == 3'd0)) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fifo_count_next = fifo_count_reg;
    case ({push, pop})
      2'b10:   fifo_count_next = fifo_count_reg + 2'd1;
      2'b01:   fifo_count_next = fifo_count_reg - 2'd1;
      default: fifo_count_next = fifo_count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_reg      <= IDLE;
      cur_addr_reg   <= '0;
      remaining_reg  <= '0;
      inflight_reg   <= 1'b0;
      done_reg       <= 1'b0;
      fifo_count_reg <= 2'd0;
      rd_ptr_reg     <= 1'b0;
      wr_ptr_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cur_addr_reg   <= cur_addr_next;
      remaining_reg  <= remaining_next;
      inflight_reg   <= inflight_next;
      done_reg       <= done_next;
      fifo_count_reg <= fifo_count_next;
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
    end
  end

  // Buffer storage; entries clear on reset so streamData reads 0.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
          fifo_mem[gi] <= '0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          fifo_mem[gi] <= ramDataOut;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_ram_stream_reader.sv
module tb_ram_stream_reader;

  localparam int DW = 12;
  localparam int DEPTH = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rstN;
  logic          start;
  logic [AW-1:0] startAddr;
  logic [AW:0]   wordCount;
  logic          ramWrEn;
  logic [DW-1:0] ramDataIn;
  logic [AW-1:0] ramAddress;
  logic [DW-1:0] ramDataOut;
  logic [DW-1:0] streamData;
  logic          streamValid;
  logic          streamReady;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  int wr_violations = 0;

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  ram_stream_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstN(rstN), .start(start), .startAddr(startAddr),
    .wordCount(wordCount), .ramWrEn(ramWrEn), .ramDataIn(ramDataIn),
    .ramAddress(ramAddress), .ramDataOut(ramDataOut), .streamData(streamData),
    .streamValid(streamValid), .streamReady(streamReady), .busy(busy), .done(done)
  );

  // Single-port RAM with registered read.
  always @(posedge clk) begin
    if (ramWrEn) mem[ramAddress] <= ramDataIn;
    ramDataOut <= mem[ramAddress];
  end

  always @(posedge clk) begin
    if (ramWrEn !== 1'b0 || ramDataIn !== '0) wr_violations++;
  end

  typedef struct packed {
    logic [2:0]        start_addr;
    logic [3:0]        word_count;
    logic              rand_ready;
    logic              mid_start;
    logic [7:0]        exp_first;   // cycle index of first valid, 255 = never
    logic [7:0]        exp_done;    // cycle index of done, 255 = not checked
    logic [0:7][2:0]   exp_addr;
    logic [0:7][11:0]  exp_data;
  } vec_t;

  vec_t vecs [7];
  vec_t post_reset_vec;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int idx, got, first_valid, done_idx, done_cnt, busy_seen, n;
    logic [DW-1:0] prev_data;
    logic prev_stall;
    idx = 0; got = 0; first_valid = -1; done_idx = -1; done_cnt = 0; busy_seen = 0;
    prev_data = '0; prev_stall = 1'b0;
    n = int'(v.word_count);
    @(negedge clk);
    startAddr = v.start_addr;
    wordCount = v.word_count;
    streamReady = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (idx < 60 && !(done_idx >= 0 && idx > done_idx + 4)) begin
      @(negedge clk);
      streamReady = v.rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v.mid_start) begin
        start = (idx == 3);
        if (idx == 3) begin
          startAddr = 3'd5;
          wordCount = 4'd2;
        end
      end
      if (prev_stall) check($sformatf("v%0d_hold", id), streamData, prev_data);
      if (idx == 0 && n != 0) check($sformatf("v%0d_busy_start", id), busy, 1'b1);
      if (streamValid && first_valid < 0) first_valid = idx;
      if (busy) busy_seen++;
      if (done) begin
        done_cnt++;
        if (done_idx < 0) done_idx = idx;
        check($sformatf("v%0d_busy_with_done", id), busy, 1'b0);
      end
      if (done_idx >= 0 && idx > done_idx)
        check($sformatf("v%0d_idle_after", id), {30'd0, streamValid, busy}, 32'd0);
      if (!v.rand_ready && idx < n)
        check($sformatf("v%0d_addr%0d", id, idx), ramAddress, v.exp_addr[idx]);
      if (streamValid && streamReady) begin
        $display("vec %0d word %0d data %0d", id, got, streamData);
        if (got < n) check($sformatf("v%0d_data%0d", id, got), streamData, v.exp_data[got]);
        else check($sformatf("v%0d_extra_word", id), got, n - 1);
        got++;
      end
      prev_stall = streamValid && !streamReady;
      prev_data = streamData;
      idx++;
    end
    start = 1'b0;
    check($sformatf("v%0d_word_total", id), got, n);
    check($sformatf("v%0d_done_pulses", id), done_cnt, 1);
    check($sformatf("v%0d_first_valid", id), first_valid,
          (v.exp_first == 8'hFF) ? -1 : int'(v.exp_first));
    if (v.exp_done != 8'hFF) check($sformatf("v%0d_done_cycle", id), done_idx, int'(v.exp_done));
    if (n == 0) check($sformatf("v%0d_busy_never", id), busy_seen, 0);
  endtask

  initial begin
    int hs;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = DW'(100 + i);
      ref_mem[i] = DW'(100 + i);
    end
    vecs[0] = '{3'd2, 4'd4, 1'b0, 1'b0, 8'd2, 8'd6,
                {3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0},
                {12'd102, 12'd103, 12'd104, 12'd105, 12'd0, 12'd0, 12'd0, 12'd0}};
    vecs[1] = '{3'd6, 4'd4, 1'b0, 1'b0, 8'd2, 8'd6,
                {3'd6, 3'd7, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0},
                {12'd106, 12'd107, 12'd100, 12'd101, 12'd0, 12'd0, 12'd0, 12'd0}};
    vecs[2] = '{3'd0, 4'd8, 1'b1, 1'b0, 8'd2, 8'hFF,
                {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
                {12'd100, 12'd101, 12'd102, 12'd103, 12'd104, 12'd105, 12'd106, 12'd107}};
    vecs[3] = '{3'd0, 4'd0, 1'b0, 1'b0, 8'hFF, 8'd0,
                {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
                {12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0}};
    vecs[4] = '{3'd7, 4'd1, 1'b0, 1'b0, 8'd2, 8'd3,
                {3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
                {12'd107, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0}};
    vecs[5] = '{3'd3, 4'd8, 1'b0, 1'b0, 8'd2, 8'd10,
                {3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2},
                {12'd103, 12'd104, 12'd105, 12'd106, 12'd107, 12'd100, 12'd101, 12'd102}};
    vecs[6] = '{3'd1, 4'd3, 1'b0, 1'b1, 8'd2, 8'd5,
                {3'd1, 3'd2, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
                {12'd101, 12'd102, 12'd103, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0}};
    post_reset_vec = '{3'd5, 4'd2, 1'b0, 1'b0, 8'd2, 8'd4,
                {3'd5, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
                {12'd105, 12'd106, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0}};

    rstN = 1'b0; start = 1'b0; startAddr = '0; wordCount = '0; streamReady = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", {busy, done, streamValid, ramAddress, streamData}, 0);
    rstN = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 7; v++) run_vec(vecs[v], v);

    // Asynchronous reset after the second word of a long transfer.
    @(negedge clk);
    startAddr = 3'd0; wordCount = 4'd8; streamReady = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    hs = 0;
    for (int c = 0; c < 20 && hs < 2; c++) begin
      @(negedge clk);
      if (streamValid && streamReady) hs++;
    end
    check("rst_reached_2nd_word", hs, 2);
    @(posedge clk);
    #2 check("rst_pre_busy", busy, 1'b1);
    rstN = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", streamValid, 1'b0);
    check("rst_data", streamData, 0);
    check("rst_addr", ramAddress, 0);
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_quiet", {done, busy, streamValid}, 0);
    end
    rstN = 1'b1;
    @(negedge clk);
    check("rst_release_quiet", {done, busy, streamValid}, 0);
    run_vec(post_reset_vec, 7);

    check("ram_write_attempts", wr_violations, 0);
    for (int i = 0; i < DEPTH; i++) check($sformatf("mem%0d_unchanged", i), mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
